// File: rtl/rv_fetch_buffer.sv
// Instruction fetch/alignment stage: word-aligned reads from instruction memory,
// a 4-parcel halfword queue, and one 16- or 32-bit instruction per output handshake.
module rv_fetch_buffer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        out_compressed
);

    logic [15:0] parcel_q [4];
    logic [1:0]  rd_ptr;
    logic [2:0]  count;
    logic [31:0] head_pc;
    logic [31:0] fetch_addr;
    logic        skip_low;
    logic        outstanding;
    logic        drop;

    logic [15:0] h0;
    logic [15:0] h1;
    logic        is_c;
    logic        inst_avail;
    logic        req_fire;
    logic        resp_fire;
    logic        out_fire;
    logic [2:0]  pop_n;
    logic [2:0]  push_n;
    logic [1:0]  wr_ptr;

    assign h0   = parcel_q[rd_ptr];
    assign h1   = parcel_q[rd_ptr + 2'd1];
    assign is_c = (h0[1:0] != 2'b11);

    // NOTE: every combinational output gets a default-free full assignment, so no latch can be inferred.
    always_comb begin
        inst_avail     = is_c ? (count >= 3'd1) : (count >= 3'd2);
        out_valid      = reset_n & ~redirect & inst_avail;
        out_inst       = is_c ? {16'h0000, h0} : {h1, h0};
        out_pc         = head_pc;
        out_compressed = is_c;
        mem_req_valid  = reset_n & ~outstanding & (count <= 3'd2) & ~redirect;
        mem_req_addr   = fetch_addr;
    end

    assign req_fire  = mem_req_valid & mem_req_ready;
    assign resp_fire = mem_resp_valid & outstanding;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        pop_n  = 3'd0;
        push_n = 3'd0;
        if (out_fire)
            pop_n = is_c ? 3'd1 : 3'd2;
        if (resp_fire && !drop)
            push_n = skip_low ? 3'd1 : 3'd2;
    end

    // Push position is relative to the pre-pop head; a same-cycle pop never moves it.
    assign wr_ptr = rd_ptr + count[1:0];

    // NOTE: parcel storage carries no reset; count alone decides which entries are meaningful.
    always_ff @(posedge clock) begin
        if (resp_fire && !drop && !redirect) begin
            if (skip_low) begin
                parcel_q[wr_ptr] <= mem_resp_data[31:16];
            end else begin
                parcel_q[wr_ptr]        <= mem_resp_data[15:0];
                parcel_q[wr_ptr + 2'd1] <= mem_resp_data[31:16];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr      <= 2'd0;
            count       <= 3'd0;
            head_pc     <= {RESET_PC[31:1], 1'b0};
            fetch_addr  <= {RESET_PC[31:2], 2'b00};
            skip_low    <= RESET_PC[1];
            outstanding <= 1'b0;
            drop        <= 1'b0;
        end else if (redirect) begin
            count      <= 3'd0;
            head_pc    <= {redirect_pc[31:1], 1'b0};
            fetch_addr <= {redirect_pc[31:2], 2'b00};
            skip_low   <= redirect_pc[1];
            // A stale in-flight read must still be absorbed before fetching again.
            if (outstanding && !mem_resp_valid) begin
                drop <= 1'b1;
            end else if (outstanding) begin
                outstanding <= 1'b0;
                drop        <= 1'b0;
            end
        end else begin
            count  <= count - pop_n + push_n;
            rd_ptr <= rd_ptr + pop_n[1:0];
            if (out_fire)
                head_pc <= head_pc + (is_c ? 32'd2 : 32'd4);
            if (req_fire) begin
                outstanding <= 1'b1;
                fetch_addr  <= fetch_addr + 32'd4;
            end
            if (resp_fire) begin
                outstanding <= 1'b0;
                if (drop)
                    drop <= 1'b0;
                else if (skip_low)
                    skip_low <= 1'b0;
            end
        end
    end

endmodule

// File: doc/rv_fetch_buffer.md
Name: rv_fetch_buffer

Overview:
Instruction fetch/alignment stage that sits directly upstream of the instruction decoder. It issues word-aligned reads to instruction memory and queues the returned data as 16-bit parcels. It then presents one complete instruction per handshake: 32-bit, or 16-bit compressed, possibly straddling a word boundary. The decoder (or a compressed expander in front of it) consumes out_inst; redirects from branch/jump resolution flush the stage.

Parameters:
RESET_PC, 32'h0000_0000, PC of the first instruction after reset; bit 0 ignored.

Ports:
clock  input  1  clock; all state on rising edge
reset_n  input  1  asynchronous, active-low reset
redirect  input  1  flush and restart fetch at redirect_pc
redirect_pc  input  32  new PC; bit 0 ignored (treated as 0)
mem_req_valid  output  1  read request valid
mem_req_ready  input  1  memory accepts request
mem_req_addr  output  32  word-aligned read address, bits[1:0]=0
mem_resp_valid  input  1  read data valid, one per accepted request, in order
mem_resp_data  input  32  read data, little-endian
out_valid  output  1  out_inst/out_pc valid
out_ready  input  1  consumer accepts instruction
out_inst  output  32  instruction; {16'b0, parcel} when compressed
out_pc  output  32  PC of out_inst
out_compressed  output  1  1 when out_inst[1:0] != 2'b11

Behaviour:
- State: parcel queue of 4 halfwords with count 0..4; head_pc; fetch_addr (word aligned); skip_low; outstanding; drop.
- Reset (reset_n low, async):
  - count=0; head_pc=RESET_PC & ~1; fetch_addr={RESET_PC[31:2],2'b00}; skip_low=RESET_PC[1]; outstanding=0; drop=0.
  - While reset_n is low: mem_req_valid=0, out_valid=0. Other outputs are don't-care.
- Request:
  - mem_req_valid = ~outstanding & (count<=2) & ~redirect.
  - mem_req_addr=fetch_addr.
  - Once asserted, valid and address stay stable until mem_req_ready.
  - On handshake: outstanding<=1, fetch_addr<=fetch_addr+4 (wraps mod 2^32).
  - At most one request is outstanding. A response is never expected in the cycle its request is accepted.
- Response (mem_resp_valid while outstanding):
  - Clear outstanding.
  - If drop: discard the data, clear drop.
  - Else if skip_low: push mem_resp_data[31:16] only, clear skip_low.
  - Else: push [15:0] then [31:16].
  - mem_resp_valid while ~outstanding is ignored.
- Output, with h0 = queue head and h1 = next parcel:
  - If h0[1:0]!=2'b11: compressed. out_valid = count>=1. out_inst={16'b0,h0}.
  - Else: out_valid = count>=2. out_inst={h1,h0}.
  - out_pc=head_pc.
  - out_valid is forced 0 while redirect=1.
  - out_inst/out_pc are don't-care when out_valid=0.
  - On handshake: pop 1 parcel and head_pc+=2 (compressed), else pop 2 and head_pc+=4.
- Same-cycle push and pop: the pop applies to old contents, the push appends. No overflow is possible, since requests issue only at count<=2.
- Redirect has highest priority over pop, push and request:
  - count<=0; head_pc<=redirect_pc&~1; fetch_addr<={redirect_pc[31:2],2'b00}; skip_low<=redirect_pc[1].
  - If outstanding and no response this cycle: drop<=1, and outstanding stays 1.
  - If a response arrives in the redirect cycle, it is discarded and outstanding clears.
- Back-to-back redirects: the last one wins; drop stays set until the stale response arrives.
- Reset mid-operation: all state returns to reset values immediately. A response for a pre-reset request is the environment's responsibility; the bench resets memory alongside.

Test Plan:
1. RESET_PC=0; mem[0]=32'h00a00093, mem[4]=32'h00000013, out_ready=1 -> out (pc 0, inst 00a00093, compressed 0), then (pc 4, inst 00000013); first mem_req_addr=0, next=4.
2. mem[0]=32'h00934505, mem[4]=32'h450500a0 -> (pc 0, inst 00004505, c=1), (pc 2, inst 00a00093, c=0), (pc 6, inst 00004505, c=1).
3. Request to 0x8 outstanding; redirect=1, redirect_pc=0x102 -> response for 0x8 dropped; next mem_req_addr=0x100; low half discarded; first out_pc=0x102, out_inst=upper half of mem[0x100] plus next parcel.
4. out_ready=0 for 20 cycles with only 32-bit instructions -> at most 2 requests accepted, mem_req_valid low at count>=3; after release, instructions pc 0,4,… in order, none lost or duplicated.
5. mem_req_ready=0 for 5 cycles -> mem_req_valid=1 and mem_req_addr unchanged throughout; single handshake on release.
6. Assert reset_n low mid-fetch with a request outstanding -> out_valid=0 and mem_req_valid=0 immediately; after release, fetch restarts at RESET_PC.
